// File: rtl/arith_ctrl_if.sv
// rtl/arith_ctrl_if.sv - command, arithmetic-unit and result signals of arith_ctrl
interface arith_ctrl_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] cmd_a;
    logic [15:0] cmd_b;
    logic [2:0]  cmd_opcode;
    logic [15:0] au_a;
    logic [15:0] au_b;
    logic [2:0]  au_opcode;
    logic [15:0] au_result;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_data;
    logic [2:0]  res_opcode;
    logic        busy;
    logic [7:0]  done_cnt;

    modport master (
        output cmd_valid, cmd_a, cmd_b, cmd_opcode, au_result, res_ready,
        input  cmd_ready, au_a, au_b, au_opcode, res_valid, res_data, res_opcode, busy, done_cnt
    );

    modport slave (
        input  cmd_valid, cmd_a, cmd_b, cmd_opcode, au_result, res_ready,
        output cmd_ready, au_a, au_b, au_opcode, res_valid, res_data, res_opcode, busy, done_cnt
    );
endinterface

// File: rtl/arith_ctrl.sv
// rtl/arith_ctrl.sv - command FIFO feeding an external arithmetic unit, one result held per handshake
module arith_ctrl #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    arith_ctrl_if.slave  bus
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {IDLE, DRIVE, HOLD} state_e;

    state_e         state_q;
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic [34:0]    mem_q [FIFO_DEPTH];
    logic [15:0]    au_a_q, au_b_q, res_data_q;
    logic [2:0]     au_opcode_q, res_opcode_q;
    logic           res_valid_q;
    logic [7:0]     done_cnt_q;
    logic           cmd_ready_w, push, pop;
    logic [34:0]    head;

    // Occupancy is registered, so a push into an empty queue cannot be popped on the same edge.
    assign cmd_ready_w = (count_q < CW'(FIFO_DEPTH));
    assign push        = bus.cmd_valid && cmd_ready_w;
    assign pop         = (count_q != '0) &&
                         ((state_q == IDLE) || ((state_q == HOLD) && bus.res_ready));
    assign head        = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = (wr_ptr_q == AW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == AW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {bus.cmd_a, bus.cmd_b, bus.cmd_opcode};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            au_a_q       <= '0;
            au_b_q       <= '0;
            au_opcode_q  <= '0;
            res_data_q   <= '0;
            res_opcode_q <= '0;
            res_valid_q  <= 1'b0;
            done_cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pop) begin
                        {au_a_q, au_b_q, au_opcode_q} <= head;
                        state_q <= DRIVE;
                    end
                end
                DRIVE: begin
                    res_data_q   <= bus.au_result;
                    res_opcode_q <= au_opcode_q;
                    res_valid_q  <= 1'b1;
                    state_q      <= HOLD;
                end
                HOLD: begin
                    if (bus.res_ready) begin
                        res_valid_q <= 1'b0;
                        done_cnt_q  <= done_cnt_q + 8'd1;
                        if (pop) begin
                            {au_a_q, au_b_q, au_opcode_q} <= head;
                            state_q <= DRIVE;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.cmd_ready  = cmd_ready_w;
    assign bus.au_a       = au_a_q;
    assign bus.au_b       = au_b_q;
    assign bus.au_opcode  = au_opcode_q;
    assign bus.res_valid  = res_valid_q;
    assign bus.res_data   = res_data_q;
    assign bus.res_opcode = res_opcode_q;
    assign bus.done_cnt   = done_cnt_q;
    assign bus.busy       = (state_q != IDLE) || (count_q != '0);
endmodule
